// File: rtl/cmp_pkg.sv
// Shared definitions for the magnitude comparator family: FSM states and
// the one-hot eq/gt/lt result encoding.
package cmp_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_e;

   typedef struct packed {
      logic eq;
      logic gt;
      logic lt;
   } cmp_res_t;

   localparam cmp_res_t RES_NONE = 3'b000;
   localparam cmp_res_t RES_EQ   = 3'b100;
   localparam cmp_res_t RES_GT   = 3'b010;
   localparam cmp_res_t RES_LT   = 3'b001;

   // Packs the ordering outputs of a 1-bit cell into a result word.
   function automatic cmp_res_t cell_order(input logic gt, input logic lt);
      cmp_res_t r;
      r    = RES_NONE;
      r.gt = gt;
      r.lt = lt;
      return r;
   endfunction

endpackage

// File: rtl/comparator_1bit.sv
// Single-bit magnitude cell: exactly one of eq/gt/lt is high for any input.
module comparator_1bit (
   input  logic a,
   input  logic b,
   output logic eq,
   output logic gt,
   output logic lt
);

   assign eq = ~(a ^ b);
   assign gt = a & ~b;
   assign lt = ~a & b;

endmodule

// File: rtl/serial_magnitude_comparator.sv
// MSB-first bit-serial unsigned comparator. One bit per clock through a
// shared 1-bit cell, exiting at the first differing bit.
module serial_magnitude_comparator
   import cmp_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             eq,
   output logic             gt,
   output logic             lt
);

   localparam int unsigned    IDX_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(WIDTH - 1);

   state_e           state_q, state_d;
   logic [IDX_W-1:0] idx_q,   idx_d;
   logic [WIDTH-1:0] a_q,     a_d;
   logic [WIDTH-1:0] b_q,     b_d;
   cmp_res_t         res_q,   res_d;
   logic             busy_q,  busy_d;
   logic             done_q,  done_d;

   logic cell_eq, cell_gt, cell_lt;

   comparator_1bit u_cell (
      .a  (a_q[idx_q]),
      .b  (b_q[idx_q]),
      .eq (cell_eq),
      .gt (cell_gt),
      .lt (cell_lt)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= RES_NONE;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   // Next-state: accept in IDLE, walk down from the MSB in RUN.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      busy_d  = 1'b0;
      done_d  = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               a_d     = a;
               b_d     = b;
               idx_d   = IDX_MSB;
               res_d   = RES_NONE;
               busy_d  = 1'b1;
               state_d = RUN;
            end
         end
         RUN: begin
            if (!cell_eq) begin
               res_d   = cell_order(cell_gt, cell_lt);
               done_d  = 1'b1;
               state_d = IDLE;
            end else if (idx_q == '0) begin
               res_d   = RES_EQ;
               done_d  = 1'b1;
               state_d = IDLE;
            end else begin
               idx_d  = idx_q - IDX_W'(1);
               busy_d = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign busy = busy_q;
   assign done = done_q;
   assign eq   = res_q.eq;
   assign gt   = res_q.gt;
   assign lt   = res_q.lt;

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Bench for serial_magnitude_comparator: directed cases with literal
// expectations plus a randomized sweep against a latency/ordering model.
module tb_serial_magnitude_comparator;

   localparam int unsigned WIDTH = 8;
   localparam int unsigned BOUND = 2 * WIDTH + 4;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             start = 1'b0;
   logic [WIDTH-1:0] a = '0;
   logic [WIDTH-1:0] b = '0;
   logic             busy, done, eq, gt, lt;

   int checks = 0;
   int passes = 0;
   bit chk_en = 1'b0;

   serial_magnitude_comparator #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .busy  (busy),
      .done  (done),
      .eq    (eq),
      .gt    (gt),
      .lt    (lt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // Latency = WIDTH - (highest differing bit), or WIDTH when equal.
   function automatic int lat_of(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
      for (int k = WIDTH - 1; k >= 0; k--)
         if (x[k] != y[k]) return WIDTH - k;
      return WIDTH;
   endfunction

   // {eq,gt,lt} from plain unsigned arithmetic.
   function automatic logic [2:0] res_of(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
      if (x == y) return 3'b100;
      if (x > y)  return 3'b010;
      return 3'b001;
   endfunction

   // Cycle-level expectation: an accepted request is busy for lat cycles,
   // then a one-cycle done with its result, which then holds.
   bit         m_busy = 1'b0;
   bit         m_done = 1'b0;
   logic [2:0] m_res  = 3'b000;
   logic [2:0] m_pend = 3'b000;
   int         m_left = 0;

   always @(posedge clk) begin
      if (rst) begin
         m_busy = 1'b0;
         m_done = 1'b0;
         m_res  = 3'b000;
         m_left = 0;
      end else begin
         m_done = 1'b0;
         if (m_busy) begin
            m_left--;
            if (m_left == 0) begin
               m_busy = 1'b0;
               m_done = 1'b1;
               m_res  = m_pend;
            end
         end else if (start) begin
            m_busy = 1'b1;
            m_left = lat_of(a, b);
            m_pend = res_of(a, b);
            m_res  = 3'b000;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("outputs{busy,done,eq,gt,lt}", 64'({busy, done, eq, gt, lt}),
             64'({m_busy, m_done, m_res}));
         chk("busy_done_exclusive", 64'(busy & done), 64'(0));
      end
   end

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   // Issues one request (DUT must be idle or in its done cycle) and waits for done.
   task automatic run_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                         input bit toggle, output int lat, output logic [2:0] res,
                         output int busy_cyc, output logic [2:0] clr);
      start = 1'b1;
      a     = av;
      b     = bv;
      cycle();
      start    = 1'b0;
      clr      = {eq, gt, lt};
      lat      = 0;
      res      = 3'b000;
      busy_cyc = busy ? 1 : 0;
      for (int n = 1; n <= int'(BOUND); n++) begin
         if (toggle) begin
            start = 1'($urandom_range(0, 1));
            a     = WIDTH'($urandom);
            b     = WIDTH'($urandom);
         end
         cycle();
         if (done) begin
            lat = n;
            res = {eq, gt, lt};
            break;
         end
         if (busy) busy_cyc++;
      end
      start = 1'b0;
      chk("done_within_bound", 64'(lat != 0), 64'(1));
   endtask

   int         lat, bcyc, dcount;
   logic [2:0] res, clr;
   logic [WIDTH-1:0] ra, rb;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      repeat (3) cycle();
      chk("reset_outputs", 64'({busy, done, eq, gt, lt}), 64'(0));
      chk_en = 1'b1;
      rst    = 1'b0;
      repeat (2) cycle();

      run_op(8'h80, 8'h7F, 1'b0, lat, res, bcyc, clr);
      chk("80v7F_latency", 64'(lat), 64'(1));
      chk("80v7F_result", 64'(res), 64'(3'b010));
      chk("80v7F_busy_cycles", 64'(bcyc), 64'(1));
      cycle();
      chk("80v7F_result_holds", 64'({done, eq, gt, lt}), 64'(4'b0010));
      repeat (2) cycle();

      run_op(8'h5A, 8'h5A, 1'b0, lat, res, bcyc, clr);
      chk("5Av5A_latency", 64'(lat), 64'(8));
      chk("5Av5A_result", 64'(res), 64'(3'b100));
      run_op(8'h00, 8'h00, 1'b0, lat, res, bcyc, clr);
      chk("00v00_latency", 64'(lat), 64'(8));
      chk("00v00_result", 64'(res), 64'(3'b100));
      chk("00v00_cleared_on_accept", 64'(clr), 64'(0));

      run_op(8'h12, 8'h13, 1'b0, lat, res, bcyc, clr);
      chk("12v13_latency", 64'(lat), 64'(8));
      chk("12v13_result", 64'(res), 64'(3'b001));
      repeat (1) cycle();
      run_op(8'h10, 8'h00, 1'b0, lat, res, bcyc, clr);
      chk("10v00_latency", 64'(lat), 64'(4));
      chk("10v00_result", 64'(res), 64'(3'b010));

      // Back-to-back: start raised in the done cycle of the previous request.
      run_op(8'h01, 8'h02, 1'b0, lat, res, bcyc, clr);
      chk("b2b_cleared_next_cycle", 64'(clr), 64'(0));
      chk("b2b_01v02_latency", 64'(lat), 64'(7));
      chk("b2b_01v02_result", 64'(res), 64'(3'b001));

      run_op(8'h3C, 8'h34, 1'b1, lat, res, bcyc, clr);
      chk("toggle_3Cv34_latency", 64'(lat), 64'(5));
      chk("toggle_3Cv34_result", 64'(res), 64'(3'b010));

      // Reset during the third RUN cycle aborts without a done.
      cycle();
      start = 1'b1;
      a     = 8'h01;
      b     = 8'h01;
      cycle();
      start = 1'b0;
      cycle();
      cycle();
      rst = 1'b1;
      cycle();
      chk("rst_abort_outputs", 64'({busy, done, eq, gt, lt}), 64'(0));
      rst    = 1'b0;
      dcount = 0;
      for (int i = 0; i < 12; i++) begin
         cycle();
         if (done) dcount++;
      end
      chk("rst_abort_no_done", 64'(dcount), 64'(0));
      run_op(8'hA7, 8'hA5, 1'b0, lat, res, bcyc, clr);
      chk("post_rst_latency", 64'(lat), 64'(7));
      chk("post_rst_result", 64'(res), 64'(3'b010));

      for (int i = 0; i < 1000; i++) begin
         ra = WIDTH'($urandom);
         case ($urandom_range(0, 2))
            0:       rb = ra;
            1:       rb = ra ^ (WIDTH'(1) << $urandom_range(0, WIDTH - 1));
            default: rb = WIDTH'($urandom);
         endcase
         run_op(ra, rb, ($urandom_range(0, 3) == 0), lat, res, bcyc, clr);
         chk("rand_latency", 64'(lat), 64'(lat_of(ra, rb)));
         chk("rand_result", 64'(res), 64'(res_of(ra, rb)));
         chk("rand_one_hot", 64'($countones(res)), 64'(1));
         if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) cycle();
      end

      cycle();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
